// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer.
//   op_e     : command opcodes. Bit 1 selects RX, bit 0 selects MSB-first.
//   state_e  : sequencer FSM states.
//   MODE_*   : universal shift register mode encodings (hold / shift R / shift L / load).
//   op_is_rx / op_is_msb : opcode field decoders.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_TX_LSB = 2'b00,
    OP_TX_MSB = 2'b01,
    OP_RX_LSB = 2'b10,
    OP_RX_MSB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_R    = 2'b01;
  localparam logic [1:0] MODE_L    = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic op_is_rx(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_msb(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/shift_bit_timer.sv
// Bit-period divider plus bit counter for the shift sequencer.
//   clk, rst    : clock, synchronous active-high reset
//   i_en        : high while the sequencer is shifting; low clears both counters
//   i_div       : period length minus one (divider counts 0..i_div)
//   i_len       : number of bit periods in the transfer (1..WIDTH)
//   o_bit_tick  : last cycle of the current bit period
//   o_last_bit  : last cycle of the final bit period
module shift_bit_timer #(
  parameter int DIV_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_bit_tick,
  output logic             o_last_bit
);

  logic [DIV_W-1:0] r_div_cnt;
  logic [LEN_W-1:0] r_bit_cnt;
  logic             w_tick;

  assign w_tick     = i_en && (r_div_cnt == i_div);
  assign o_bit_tick = w_tick;
  assign o_last_bit = w_tick && (r_bit_cnt == (i_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving an external universal shift register for one serial transfer per
// command (TX parallel-to-serial or RX serial-to-parallel, LSB- or MSB-first).
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/ready       : command handshake; cmd_op/len/div/data are the command fields
//   rsp_valid/ready       : response handshake; rsp_data is the transfer result
//   sr_mode, sr_par_in,
//   sr_sin_L, sr_sin_R    : controls to the shift register
//   sr_q                  : shift register contents
//   ser_out, ser_in       : serial line
//   busy                  : high from command accept until the response handshake
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DIV_W = 8,
  localparam int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_par_in,
  output logic             sr_sin_L,
  output logic             sr_sin_R,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  op_e              r_op;
  logic [LEN_W-1:0] r_len;
  logic [DIV_W-1:0] r_div;
  logic [WIDTH-1:0] r_data;

  logic [LEN_W-1:0] w_len_eff;
  logic             w_shift_en;
  logic             w_bit_tick;
  logic             w_last_bit;
  logic             w_rx;
  logic             w_msb;

  // A zero or oversized length means a full-width transfer.
  assign w_len_eff  = ((cmd_len == '0) || (cmd_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : cmd_len;
  assign w_shift_en = (r_state == S_SHIFT);
  assign w_rx       = op_is_rx(r_op);
  assign w_msb      = op_is_msb(r_op);

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid  = (r_state == S_DONE);

  shift_bit_timer #(
    .DIV_W (DIV_W),
    .LEN_W (LEN_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_shift_en),
    .i_div      (r_div),
    .i_len      (r_len),
    .o_bit_tick (w_bit_tick),
    .o_last_bit (w_last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_TX_LSB;
      r_len   <= '0;
      r_div   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= op_e'(cmd_op);
            r_len   <= w_len_eff;
            r_div   <= cmd_div;
            r_data  <= cmd_data;
            r_state <= S_LOAD;
          end
        end
        S_LOAD:  r_state <= S_SHIFT;
        S_SHIFT: if (w_last_bit) r_state <= S_DONE;
        S_DONE:  if (rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Register controls are decoded from state so a reset returns them to idle values
  // on the very next cycle. The register only moves on the last cycle of a period,
  // so ser_out taken straight from sr_q stays constant for the whole period.
  always_comb begin
    sr_mode   = MODE_HOLD;
    sr_par_in = '0;
    sr_sin_L  = 1'b0;
    sr_sin_R  = 1'b0;
    ser_out   = 1'b0;
    rsp_data  = '0;
    case (r_state)
      S_LOAD: begin
        sr_mode = MODE_LOAD;
        if (!w_rx) sr_par_in = r_data;
      end
      S_SHIFT: begin
        if (!w_rx) ser_out = w_msb ? sr_q[WIDTH-1] : sr_q[0];
        if (w_bit_tick) begin
          sr_mode = w_msb ? MODE_L : MODE_R;
          if (w_rx) begin
            if (w_msb) sr_sin_L = ser_in;
            else       sr_sin_R = ser_in;
          end
        end
      end
      S_DONE: begin
        // LSB-first RX fills from the top, so right-justify the received bits.
        if (r_op == OP_RX_LSB) rsp_data = sr_q >> (LEN_W'(WIDTH) - r_len);
        else                   rsp_data = sr_q;
      end
      default: ;
    endcase
  end

endmodule
